// File: rtl/checker_ram_to_wb_pkg.sv
// Shared definitions for the RAM-to-Wishbone drain engine.
//  - Default geometry: 12-bit row address, 13-bit row count, 255-cycle bus timeout.
//  - Bank count (8 byte-wide banks form one 64-bit row).
//  - FSM state encoding, also exposed on the debug port.
//  - pack_beat: builds a 32-bit write word, lowest bank in the top byte.
package checker_ram_to_wb_pkg;

    localparam int ROW_W_DEF = 12;
    localparam int LEN_W_DEF = 13;
    localparam int TMO_DEF   = 255;
    localparam int NBANK     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RADR = 3'd1,
        ST_RLAT = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    function automatic logic [31:0] pack_beat(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/checker_ram_to_wb_if.sv
// Wishbone classic bus bundle.
//  master: drives adr/dat/sel/cyc/stb/we, receives ack/err.
//  slave : the reverse.
// Handshake: a beat is offered while cyc & stb are high; adr/dat/sel/we stay
// stable until the slave answers with ack or err in some cycle where stb is
// high. The beat ends on that clock edge.
interface checker_ram_to_wb_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;

    modport master (output adr, dat, sel, cyc, stb, we, input ack, err);
    modport slave  (input adr, dat, sel, cyc, stb, we, output ack, err);
endinterface

// File: rtl/checker_ram_to_wb_beat.sv
// Single-beat Wishbone classic write engine.
//  sys_clk, sys_rst_n : clock, asynchronous active-low reset
//  req_i              : accepted only while no beat is open; adr_i/dat_i latched then
//  end_o              : combinational, high in the stb cycle that closes the beat
//  err_o              : combinational, beat closed by wb err or by timeout
//  wb                 : bus master port
// After a beat closes, cyc/stb are low for at least one cycle before the next
// request can open a new one.
module checker_ram_to_wb_beat #(
    parameter int TMO = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        end_o,
    output logic        err_o,
    checker_ram_to_wb_if.master wb
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    logic        stb_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [7:0]  cnt_q;
    logic        tmo_hit;

    // cnt_q counts completed stb cycles of the open beat; the TMO-th stb cycle
    // without a response closes the beat exactly like a bus error.
    assign tmo_hit = stb_q && (cnt_q == TMO_LAST);
    assign err_o   = stb_q && (wb.err || tmo_hit);
    assign end_o   = stb_q && (wb.ack || wb.err || tmo_hit);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stb_q <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else if (!stb_q) begin
            if (req_i) begin
                stb_q <= 1'b1;
                adr_q <= adr_i;
                dat_q <= dat_i;
                cnt_q <= '0;
            end
        end else if (end_o) begin
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign wb.cyc = stb_q;
    assign wb.stb = stb_q;
    assign wb.we  = stb_q;
    assign wb.sel = {4{stb_q}};
    assign wb.adr = adr_q;
    assign wb.dat = dat_q;

endmodule

// File: rtl/checker_ram_to_wb.sv
// Wishbone classic master draining the 8 byte-wide RAM banks to a WB target.
//  sys_clk, sys_rst_n       : clock, asynchronous active-low reset
//  start_i/abort_i          : begin a transfer / stop at the next safe point
//  src_row_i/len_i/dst_adr_i: first row, row count (0 = none), WB byte address
//  busy_o/done_o/err_o      : in progress / end pulse / sticky bus failure
//  ram_adr_o, ram_dat_*_i   : bank read port, data one cycle after address
//  dbg_state_o              : current FSM state
//  wb                       : WB master; two 32-bit writes per 64-bit row
module checker_ram_to_wb
    import checker_ram_to_wb_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ROW_W-1:0] src_row_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      dst_adr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [ROW_W-1:0] ram_adr_o,
    input  logic [7:0]       ram_dat_0_i,
    input  logic [7:0]       ram_dat_1_i,
    input  logic [7:0]       ram_dat_2_i,
    input  logic [7:0]       ram_dat_3_i,
    input  logic [7:0]       ram_dat_4_i,
    input  logic [7:0]       ram_dat_5_i,
    input  logic [7:0]       ram_dat_6_i,
    input  logic [7:0]       ram_dat_7_i,
    output state_t           dbg_state_o,
    checker_ram_to_wb_if.master wb
);

    localparam logic [ROW_W-1:0] ROW_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t           state_q;
    logic             busy_q, done_q, err_q, abort_q;
    logic [ROW_W-1:0] ram_adr_q;
    logic [LEN_W-1:0] rem_q;
    logic [31:0]      dst_q;
    logic [7:0]       row_buf_q [NBANK];
    logic [7:0]       ram_dat [NBANK];

    logic [ROW_W-1:0] row_d;
    logic [31:0]      dst_d;
    logic             beat_req, beat_end, beat_err;
    logic [31:0]      beat_adr, beat_dat;

    assign ram_dat[0] = ram_dat_0_i;
    assign ram_dat[1] = ram_dat_1_i;
    assign ram_dat[2] = ram_dat_2_i;
    assign ram_dat[3] = ram_dat_3_i;
    assign ram_dat[4] = ram_dat_4_i;
    assign ram_dat[5] = ram_dat_5_i;
    assign ram_dat[6] = ram_dat_6_i;
    assign ram_dat[7] = ram_dat_7_i;

    // Both counters wrap naturally at their width.
    assign row_d = ram_adr_q + ROW_ONE;
    assign dst_d = dst_q + 32'd8;

    // The beat engine only accepts a request while idle, so holding req for
    // the whole WR state issues exactly one beat per state visit.
    assign beat_req = (state_q == ST_WR0) || (state_q == ST_WR1);
    assign beat_adr = (state_q == ST_WR1) ? dst_q + 32'd4 : dst_q;
    assign beat_dat = (state_q == ST_WR1)
                    ? pack_beat(row_buf_q[4], row_buf_q[5], row_buf_q[6], row_buf_q[7])
                    : pack_beat(row_buf_q[0], row_buf_q[1], row_buf_q[2], row_buf_q[3]);

    checker_ram_to_wb_beat #(.TMO(TMO)) u_beat (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_i     (beat_req),
        .adr_i     (beat_adr),
        .dat_i     (beat_dat),
        .end_o     (beat_end),
        .err_o     (beat_err),
        .wb        (wb)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            ram_adr_q <= '0;
            rem_q     <= '0;
            dst_q     <= '0;
            for (int b = 0; b < NBANK; b++) row_buf_q[b] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i != '0) begin
                            ram_adr_q <= src_row_i;
                            rem_q     <= len_i;
                            dst_q     <= dst_adr_i & ~32'h3;
                            busy_q    <= 1'b1;
                            state_q   <= ST_RADR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_RADR: begin
                    if (abort_i) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_RLAT;
                    end
                end
                ST_RLAT: begin
                    if (abort_i) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FIN;
                    end else begin
                        for (int b = 0; b < NBANK; b++) row_buf_q[b] <= ram_dat[b];
                        state_q <= ST_WR0;
                    end
                end
                ST_WR0, ST_WR1: begin
                    // An abort seen at any point of a beat is remembered and
                    // honoured once that beat has terminated.
                    if (abort_i) abort_q <= 1'b1;
                    if (beat_end) begin
                        if (beat_err) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            if (state_q == ST_WR1) begin
                                dst_q     <= dst_d;
                                ram_adr_q <= row_d;
                                rem_q     <= rem_q - LEN_ONE;
                            end
                            if (abort_i || abort_q || (state_q == ST_WR1 && rem_q == LEN_ONE)) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_FIN;
                            end else begin
                                state_q <= (state_q == ST_WR0) ? ST_WR1 : ST_RADR;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign ram_adr_o   = ram_adr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_checker_ram_to_wb.sv
module tb_checker_ram_to_wb;
  import checker_ram_to_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [11:0] src_row_i = '0;
  logic [12:0] len_i = '0;
  logic [31:0] dst_adr_i = '0;
  logic        busy_o, done_o, err_o;
  logic [11:0] ram_adr_o;
  logic [7:0]  ram_q [8];
  state_t      dbg_state;

  checker_ram_to_wb_if wb_if ();

  checker_ram_to_wb #(.ROW_W(12), .LEN_W(13), .TMO(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .src_row_i   (src_row_i),
    .len_i       (len_i),
    .dst_adr_i   (dst_adr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .ram_adr_o   (ram_adr_o),
    .ram_dat_0_i (ram_q[0]),
    .ram_dat_1_i (ram_q[1]),
    .ram_dat_2_i (ram_q[2]),
    .ram_dat_3_i (ram_q[3]),
    .ram_dat_4_i (ram_q[4]),
    .ram_dat_5_i (ram_q[5]),
    .ram_dat_6_i (ram_q[6]),
    .ram_dat_7_i (ram_q[7]),
    .dbg_state_o (dbg_state),
    .wb          (wb_if)
  );

  // ---------------- bank RAM model (1-cycle read latency) ----------------
  function automatic logic [7:0] ram_byte(input logic [11:0] row, input int b);
    if (row == 12'd5) return 8'(b * 17);
    return 8'(int'(row) * 13 + b * 37 + 1);
  endfunction

  always @(posedge sys_clk) begin
    for (int b = 0; b < 8; b++) ram_q[b] <= ram_byte(ram_adr_o, b);
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {wb address, wb data} per expected beat

  function automatic logic [31:0] exp_word(input logic [11:0] row, input bit hi);
    if (hi) return {ram_byte(row, 0), ram_byte(row, 1), ram_byte(row, 2), ram_byte(row, 3)};
    return {ram_byte(row, 4), ram_byte(row, 5), ram_byte(row, 6), ram_byte(row, 7)};
  endfunction

  task automatic push_beats(input logic [11:0] src, input logic [31:0] dst, input int nb);
    logic [11:0] row;
    logic [31:0] a;
    for (int k = 0; k < nb; k++) begin
      row = src + 12'(k / 2);
      a = (dst & ~32'h3) + 32'(k * 4);
      exp_q.push_back({a, exp_word(row, (k % 2) == 0)});
    end
  endtask

  // ---------------- WB target model + output monitor (negedge) ----------------
  int cyc_n = 0;
  int done_cnt = 0;
  int beats = 0;
  int last_term = 0;
  int last_beat_len = 0;
  int beat_cyc = 0;
  int wait_left = 0;
  int fixed_wait = 0;     // >= 0: fixed ack delay, < 0: random 0..3
  int err_beat = -1;      // global beat number answered with err
  bit noack = 1'b0;
  bit lat_chk = 1'b0;
  bit in_beat = 1'b0;
  logic [63:0] cur_exp = '0;

  initial begin
    wb_if.ack = 1'b0;
    wb_if.err = 1'b0;
    forever begin
      @(negedge sys_clk);
      cyc_n++;
      if (done_o) begin
        done_cnt++;
        if (lat_chk) chk("done_lat", 64'(cyc_n), 64'(last_term + 1));
      end
      wb_if.ack = 1'b0;
      wb_if.err = 1'b0;
      if (wb_if.stb) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          beat_cyc = 0;
          beats++;
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3, 0));
          chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
          else cur_exp = '0;
        end
        beat_cyc++;
        chk("wb_adr", 64'(wb_if.adr), 64'(cur_exp[63:32]));
        chk("wb_dat", 64'(wb_if.dat), 64'(cur_exp[31:0]));
        chk("wb_ctl", 64'({wb_if.cyc, wb_if.we, wb_if.sel}), 64'(6'b111111));
        if (!noack) begin
          if (wait_left == 0) begin
            if (beats == err_beat) wb_if.err = 1'b1;
            else wb_if.ack = 1'b1;
            last_term = cyc_n;
          end else begin
            wait_left--;
          end
        end
      end else begin
        if (in_beat) last_beat_len = beat_cyc;
        in_beat = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int done_base = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] src, input logic [12:0] len, input logic [31:0] dst);
    done_base = done_cnt;
    src_row_i = src;
    len_i = len;
    dst_adr_i = dst;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) tick();
    chk(tag, 64'(done_cnt > done_base), 64'(1));
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && beats < target; i++) tick();
    chk("beat_wait", 64'(beats >= target), 64'(1));
  endtask

  task automatic end_checks(input string tag, input logic exp_err, input int b0, input int nbeats);
    tick();
    chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "_beats"}, 64'(beats - b0), 64'(nbeats));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_idle"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int b0;

  initial begin
    repeat (3) tick();
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_ram_adr", 64'(ram_adr_o), 64'(0));
    chk("rst_wb", 64'({wb_if.cyc, wb_if.stb, wb_if.we, wb_if.sel, wb_if.adr, wb_if.dat}), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    sys_rst_n = 1'b1;
    repeat (2) tick();

    // single row, immediate ack
    fixed_wait = 0; lat_chk = 1'b1; b0 = beats;
    push_beats(12'd5, 32'h1000, 2);
    chk("row5_w0", 64'(exp_q[0]), {32'h1000, 32'h00112233});
    chk("row5_w1", 64'(exp_q[1]), {32'h1004, 32'h44556677});
    do_start(12'd5, 13'd1, 32'h1000);
    chk("start_busy", 64'(busy_o), 64'(1));
    wait_done("t1_done", 100);
    end_checks("t1", 1'b0, b0, 2);

    // row wrap, random waits, start while busy ignored
    fixed_wait = -1; b0 = beats;
    push_beats(12'd4094, 32'h1000, 6);
    do_start(12'd4094, 13'd3, 32'h1000);
    repeat (3) tick();
    src_row_i = 12'd0; len_i = 13'd5; dst_adr_i = 32'h2000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("t2_done", 200);
    end_checks("t2", 1'b0, b0, 6);
    repeat (20) tick();
    chk("t2_one_done", 64'(done_cnt), 64'(done_base + 1));
    chk("t2_no_extra", 64'(beats - b0), 64'(6));

    // destination address wrap and unaligned low bits
    b0 = beats;
    push_beats(12'd77, 32'hFFFF_FFFA, 4);
    do_start(12'd77, 13'd2, 32'hFFFF_FFFA);
    wait_done("t2b_done", 200);
    end_checks("t2b", 1'b0, b0, 4);

    // zero-length transfer; start held into the FIN cycle is ignored
    lat_chk = 1'b0; b0 = beats; done_base = done_cnt;
    src_row_i = 12'd9; len_i = 13'd0; dst_adr_i = 32'h0;
    start_i = 1'b1;
    tick();
    chk("len0_done", 64'(done_o), 64'(1));
    chk("len0_busy", 64'(busy_o), 64'(0));
    len_i = 13'd1;
    tick();
    start_i = 1'b0;
    repeat (15) tick();
    chk("len0_one_done", 64'(done_cnt), 64'(done_base + 1));
    chk("len0_no_cyc", 64'(beats - b0), 64'(0));

    // bus error on the second beat
    lat_chk = 1'b1; fixed_wait = 1; b0 = beats;
    err_beat = beats + 2;
    push_beats(12'd10, 32'h3000, 2);
    do_start(12'd10, 13'd4, 32'h3000);
    wait_done("t4_done", 200);
    end_checks("t4", 1'b1, b0, 2);
    err_beat = -1;
    b0 = beats;
    push_beats(12'd20, 32'h3100, 2);
    do_start(12'd20, 13'd1, 32'h3100);
    chk("err_clear", 64'(err_o), 64'(0));
    wait_done("t4b_done", 100);
    end_checks("t4b", 1'b0, b0, 2);

    // timeout: target never answers
    lat_chk = 1'b0; noack = 1'b1; b0 = beats;
    push_beats(12'd30, 32'h6000, 1);
    do_start(12'd30, 13'd2, 32'h6000);
    wait_done("tmo_done", 100);
    end_checks("tmo", 1'b1, b0, 1);
    chk("tmo_stb_len", 64'(last_beat_len), 64'(16));
    noack = 1'b0;

    // abort in the middle of the first beat
    lat_chk = 1'b1; fixed_wait = 3; b0 = beats;
    push_beats(12'd40, 32'h7000, 1);
    do_start(12'd40, 13'd3, 32'h7000);
    wait_beats(b0 + 1, 50);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    wait_done("abort_done", 100);
    end_checks("abort", 1'b0, b0, 1);

    // abort while reading the RAM (RADR)
    lat_chk = 1'b0; b0 = beats;
    do_start(12'd50, 13'd2, 32'h7100);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    wait_done("abort_radr_done", 20);
    end_checks("abort_radr", 1'b0, b0, 0);

    // asynchronous reset during the WR1 beat
    fixed_wait = 2; b0 = beats;
    push_beats(12'd100, 32'h4000, 4);
    do_start(12'd100, 13'd2, 32'h4000);
    wait_beats(b0 + 2, 60);
    #1;
    chk("pre_rst_stb", 64'(wb_if.stb), 64'(1));
    sys_rst_n = 1'b0;
    #1;
    chk("arst_wb", 64'({wb_if.cyc, wb_if.stb}), 64'(0));
    chk("arst_flags", 64'({busy_o, done_o, err_o}), 64'(0));
    exp_q.delete();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    fixed_wait = -1; lat_chk = 1'b1; b0 = beats;
    push_beats(12'd5, 32'h5000, 4);
    do_start(12'd5, 13'd2, 32'h5000);
    wait_done("post_rst_done", 200);
    end_checks("post_rst", 1'b0, b0, 4);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
